// File: rtl/dma_priority_arbiter_pkg.sv
// rtl/dma_priority_arbiter_pkg.sv - shared types and constants for the DMA channel arbiter
package dma_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE,
      HOLD_REQ,
      GRANT,
      RELEASE
   } arbState_t;

   typedef logic [1:0] chanIdx_t;

   localparam int       NUM_CH_C     = 4;
   localparam chanIdx_t LOWPRI_RESET = 2'd3;

   function automatic logic [NUM_CH_C-1:0] chan_onehot(input chanIdx_t idx);
      logic [NUM_CH_C-1:0] oh;
      oh      = '0;
      oh[idx] = 1'b1;
      return oh;
   endfunction

endpackage

// File: rtl/dma_priority_arbiter_if.sv
// rtl/dma_priority_arbiter_if.sv - DREQ/hold/DACK bus between the arbiter and the rest of the DMA
interface dma_priority_arbiter_if;

   logic [3:0]                  dreq;
   logic                        hlda;
   logic                        serviceDone;
   logic                        hrq;
   logic [3:0]                  dack;
   logic                        grantValid;
   dma_arbiter_pkg::chanIdx_t   grantChannel;
   logic [3:0]                  reqServed;

   modport master (
      input  dreq,
      input  hlda,
      input  serviceDone,
      output hrq,
      output dack,
      output grantValid,
      output grantChannel,
      output reqServed
   );

   modport slave (
      output dreq,
      output hlda,
      output serviceDone,
      input  hrq,
      input  dack,
      input  grantValid,
      input  grantChannel,
      input  reqServed
   );

endinterface

// File: rtl/dma_priority_arbiter_resolver.sv
// rtl/dma_priority_arbiter_resolver.sv - combinational fixed/rotating winner search over pending channels
module dma_priority_resolver
   import dma_arbiter_pkg::*;
(
   input  logic [NUM_CH_C-1:0] pend,
   input  chanIdx_t            low_pri,
   input  logic                priority_type,
   output chanIdx_t            winner,
   output logic                any_req
);

   chanIdx_t start;
   chanIdx_t idx;
   logic     found;

   // Rotating mode starts one past the last serviced channel; fixed mode always starts at 0.
   always_comb begin
      start  = priority_type ? chanIdx_t'(low_pri + 2'd1) : 2'd0;
      winner = '0;
      idx    = '0;
      found  = 1'b0;
      for (int k = 0; k < NUM_CH_C; k++) begin
         idx = chanIdx_t'(start + k[1:0]);
         if (!found && pend[idx]) begin
            winner = idx;
            found  = 1'b1;
         end
      end
   end

   assign any_req = |pend;

endmodule

// File: rtl/dma_priority_arbiter.sv
// rtl/dma_priority_arbiter.sv - DMA channel arbiter and HRQ/HLDA bus-hold sequencer
// Optional DREQ synchronizer enabled by defining DMA_DREQ_SYNC_EN.
module dma_priority_arbiter
   import dma_arbiter_pkg::*;
#(
   parameter int NUM_CH      = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                   clk,
   input  logic                   resetN,
   dma_priority_arbiter_if.master bus,
   input  logic [NUM_CH-1:0]      maskBits,
   input  logic [NUM_CH-1:0]      softReq,
   input  logic                   priorityType,
   input  logic                   dreqSense,
   input  logic                   dackSense,
   input  logic                   controllerDisable
);

   logic [NUM_CH-1:0] dreq_s;

`ifdef DMA_DREQ_SYNC_EN
   logic [SYNC_STAGES-1:0][NUM_CH-1:0] sync_q;
   logic [SYNC_STAGES-1:0][NUM_CH-1:0] sync_d;

   always_comb begin
      sync_d    = sync_q;
      sync_d[0] = bus.dreq;
      for (int s = 1; s < SYNC_STAGES; s++) begin
         sync_d[s] = sync_q[s-1];
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         sync_q <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign dreq_s = sync_q[SYNC_STAGES-1];
`else
   if (SYNC_STAGES < 1) begin : g_sync_stages_unused
   end

   assign dreq_s = bus.dreq;
`endif

   logic [NUM_CH-1:0] pend;
   chanIdx_t          winner;
   logic              any_req;

   // softReq bypasses the mask so software can always force a transfer.
   assign pend = ((dreq_s ^ {NUM_CH{dreqSense}}) & ~maskBits) | softReq;

   arbState_t         state_q,       state_d;
   logic              hrq_q,         hrq_d;
   logic              grant_valid_q, grant_valid_d;
   chanIdx_t          grant_ch_q,    grant_ch_d;
   logic [NUM_CH-1:0] req_served_q,  req_served_d;
   logic [NUM_CH-1:0] grant_oh_q,    grant_oh_d;
   chanIdx_t          low_pri_q,     low_pri_d;

   dma_priority_resolver u_resolver (
      .pend          (pend),
      .low_pri       (low_pri_q),
      .priority_type (priorityType),
      .winner        (winner),
      .any_req       (any_req)
   );

   always_comb begin
      state_d       = state_q;
      hrq_d         = hrq_q;
      grant_valid_d = grant_valid_q;
      grant_ch_d    = grant_ch_q;
      req_served_d  = '0;
      grant_oh_d    = grant_oh_q;
      low_pri_d     = low_pri_q;

      case (state_q)
         IDLE: begin
            hrq_d         = 1'b0;
            grant_valid_d = 1'b0;
            grant_oh_d    = '0;
            if (any_req && !controllerDisable) begin
               state_d = HOLD_REQ;
               hrq_d   = 1'b1;
            end
         end

         HOLD_REQ: begin
            if (!any_req || controllerDisable) begin
               state_d = IDLE;
               hrq_d   = 1'b0;
            end else if (bus.hlda) begin
               state_d       = GRANT;
               grant_ch_d    = winner;
               grant_oh_d    = chan_onehot(winner);
               grant_valid_d = 1'b1;
               hrq_d         = 1'b1;
            end
         end

         // The grant is frozen here; controllerDisable and new requests are ignored.
         GRANT: begin
            if (bus.serviceDone) begin
               state_d       = RELEASE;
               req_served_d  = grant_oh_q;
               hrq_d         = 1'b0;
               grant_valid_d = 1'b0;
               grant_oh_d    = '0;
               if (priorityType) begin
                  low_pri_d = grant_ch_q;
               end
            end else if (!bus.hlda) begin
               state_d       = IDLE;
               hrq_d         = 1'b0;
               grant_valid_d = 1'b0;
               grant_oh_d    = '0;
            end
         end

         RELEASE: begin
            hrq_d         = 1'b0;
            grant_valid_d = 1'b0;
            grant_oh_d    = '0;
            if (!bus.hlda) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d       = IDLE;
            hrq_d         = 1'b0;
            grant_valid_d = 1'b0;
            grant_oh_d    = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q       <= IDLE;
         hrq_q         <= 1'b0;
         grant_valid_q <= 1'b0;
         grant_ch_q    <= '0;
         req_served_q  <= '0;
         grant_oh_q    <= '0;
         low_pri_q     <= LOWPRI_RESET;
      end else begin
         state_q       <= state_d;
         hrq_q         <= hrq_d;
         grant_valid_q <= grant_valid_d;
         grant_ch_q    <= grant_ch_d;
         req_served_q  <= req_served_d;
         grant_oh_q    <= grant_oh_d;
         low_pri_q     <= low_pri_d;
      end
   end

   assign bus.hrq          = hrq_q;
   assign bus.grantValid   = grant_valid_q;
   assign bus.grantChannel = grant_ch_q;
   assign bus.reqServed    = req_served_q;
   assign bus.dack         = dackSense ? grant_oh_q : ~grant_oh_q;

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// tb/tb_dma_priority_arbiter.sv - self-checking bench for dma_priority_arbiter
module tb_dma_priority_arbiter;

`ifdef DMA_DREQ_SYNC_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 1;
`endif

   logic       clk;
   logic       resetN;
   logic [3:0] maskBits;
   logic [3:0] softReq;
   logic       priorityType;
   logic       dreqSense;
   logic       dackSense;
   logic       controllerDisable;

   int n_pass;
   int n_total;

   logic [1:0] exp_q[$];

   dma_priority_arbiter_if bus ();

   dma_priority_arbiter dut (
      .clk               (clk),
      .resetN            (resetN),
      .bus               (bus),
      .maskBits          (maskBits),
      .softReq           (softReq),
      .priorityType      (priorityType),
      .dreqSense         (dreqSense),
      .dackSense         (dackSense),
      .controllerDisable (controllerDisable)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic idle_out();
      bus.dreq        = 4'b0000;
      softReq         = 4'b0000;
      bus.hlda        = 1'b0;
      bus.serviceDone = 1'b0;
      step(LAT + 2);
   endtask

   // Drives one complete HRQ/HLDA/service/release cycle and records what the DUT showed.
   task automatic serve(input int hdelay, input int rel_hold,
                        output logic [1:0] ch, output logic [3:0] dk, output logic [3:0] rs,
                        output logic hrq_done, output logic hrq_rel, output bit to);
      ch = 2'b00; dk = 4'b0000; rs = 4'b0000; hrq_done = 1'b1; hrq_rel = 1'b1; to = 1'b0;
      for (int i = 0; i < 20 && bus.hrq !== 1'b1; i++) @(negedge clk);
      if (bus.hrq !== 1'b1) begin
         to = 1'b1;
         return;
      end
      step(hdelay);
      bus.hlda = 1'b1;
      for (int i = 0; i < 10 && bus.grantValid !== 1'b1; i++) @(negedge clk);
      if (bus.grantValid !== 1'b1) begin
         to = 1'b1;
         bus.hlda = 1'b0;
         return;
      end
      ch = bus.grantChannel;
      dk = bus.dack;
      bus.serviceDone = 1'b1;
      @(negedge clk);
      bus.serviceDone = 1'b0;
      rs       = bus.reqServed;
      hrq_done = bus.hrq;
      step(rel_hold);
      hrq_rel  = bus.hrq;
      bus.hlda = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      resetN = 1'b0;
      step(2);
      n_total++; if (bus.hrq !== 1'b0) $display("FAIL reset_hrq: got %b want 0", bus.hrq); else n_pass++;
      n_total++; if (bus.grantValid !== 1'b0) $display("FAIL reset_grantValid: got %b want 0", bus.grantValid); else n_pass++;
      n_total++; if (bus.grantChannel !== 2'd0) $display("FAIL reset_grantChannel: got %0d want 0", bus.grantChannel); else n_pass++;
      n_total++; if (bus.reqServed !== 4'b0000) $display("FAIL reset_reqServed: got %b want 0000", bus.reqServed); else n_pass++;
      n_total++; if (bus.dack !== 4'b1111) $display("FAIL reset_dack: got %b want 1111", bus.dack); else n_pass++;
      resetN = 1'b1;
      step(1);
   endtask

   task automatic test_fixed();
      logic [1:0] ch; logic [3:0] dk, rs; logic hd, hr; bit to; logic [1:0] e;
      priorityType = 1'b0;
      bus.dreq = 4'b1010;
      exp_q.push_back(2'd1);
      serve(2, 3, ch, dk, rs, hd, hr, to);
      e = exp_q.pop_front();
      n_total++; if (to !== 1'b0) $display("FAIL fixed_timeout: no grant seen"); else n_pass++;
      n_total++; if (ch !== e) $display("FAIL fixed_channel: got %0d want %0d", ch, e); else n_pass++;
      n_total++; if (dk !== 4'b1101) $display("FAIL fixed_dack: got %b want 1101", dk); else n_pass++;
      n_total++; if (rs !== 4'b0010) $display("FAIL fixed_reqServed: got %b want 0010", rs); else n_pass++;
      n_total++; if (hd !== 1'b0) $display("FAIL fixed_hrq_drop: got %b want 0", hd); else n_pass++;
      n_total++; if (hr !== 1'b0) $display("FAIL fixed_release_wait: got hrq %b want 0", hr); else n_pass++;
      idle_out();
   endtask

   task automatic test_rotating();
      logic [1:0] ch; logic [3:0] dk, rs; logic hd, hr; bit to; logic [1:0] e;
      priorityType = 1'b1;
      bus.dreq = 4'b1111;
      for (int k = 0; k < 5; k++) exp_q.push_back(2'(k % 4));
      for (int k = 0; k < 5; k++) begin
         serve(1, 0, ch, dk, rs, hd, hr, to);
         e = exp_q.pop_front();
         n_total++; if (ch !== e || to) $display("FAIL rot_channel_%0d: got %0d want %0d", k, ch, e); else n_pass++;
         n_total++; if (rs !== 4'(1 << e)) $display("FAIL rot_reqServed_%0d: got %b want %b", k, rs, 4'(1 << e)); else n_pass++;
      end
      idle_out();
   endtask

   task automatic test_mask_softreq();
      logic [1:0] ch; logic [3:0] dk, rs; logic hd, hr; bit to; logic [1:0] e;
      priorityType = 1'b0;
      maskBits = 4'b0100;
      bus.dreq = 4'b0100;
      step(LAT + 3);
      n_total++; if (bus.hrq !== 1'b0) $display("FAIL mask_hrq: got %b want 0", bus.hrq); else n_pass++;
      softReq = 4'b0100;
      exp_q.push_back(2'd2);
      serve(1, 0, ch, dk, rs, hd, hr, to);
      e = exp_q.pop_front();
      n_total++; if (ch !== e || to) $display("FAIL softreq_channel: got %0d want %0d", ch, e); else n_pass++;
      n_total++; if (rs !== 4'b0100) $display("FAIL softreq_reqServed: got %b want 0100", rs); else n_pass++;
      idle_out();
      maskBits = 4'b0000;
   endtask

   task automatic test_sense();
      logic [1:0] ch; logic [3:0] dk, rs; logic hd, hr; bit to; logic [1:0] e;
      priorityType = 1'b0;
      maskBits = 4'b1111;
      bus.dreq = 4'b1110;
      step(LAT + 1);
      dreqSense = 1'b1;
      dackSense = 1'b1;
      maskBits  = 4'b0000;
      exp_q.push_back(2'd0);
      serve(1, 0, ch, dk, rs, hd, hr, to);
      e = exp_q.pop_front();
      n_total++; if (ch !== e || to) $display("FAIL sense_channel: got %0d want %0d", ch, e); else n_pass++;
      n_total++; if (dk !== 4'b0001) $display("FAIL sense_dack: got %b want 0001", dk); else n_pass++;
      resetN = 1'b0;
      #1;
      n_total++; if (bus.dack !== 4'b0000) $display("FAIL sense_reset_dack: got %b want 0000", bus.dack); else n_pass++;
      maskBits  = 4'b1111;
      dreqSense = 1'b0;
      dackSense = 1'b0;
      bus.dreq  = 4'b0000;
      bus.hlda  = 1'b0;
      step(1);
      resetN = 1'b1;
      step(LAT + 1);
      maskBits = 4'b0000;
   endtask

   task automatic test_withdraw_abort_disable();
      logic [1:0] ch; logic [3:0] dk, rs; logic hd, hr; bit to; logic [1:0] e;
      bus.dreq = 4'b0001;
      step(LAT);
      n_total++; if (bus.hrq !== 1'b1) $display("FAIL withdraw_hrq_up: got %b want 1", bus.hrq); else n_pass++;
      bus.dreq = 4'b0000;
      step(LAT);
      n_total++; if (bus.hrq !== 1'b0) $display("FAIL withdraw_hrq_down: got %b want 0", bus.hrq); else n_pass++;
      idle_out();

      priorityType = 1'b1;
      bus.dreq = 4'b0010;
      exp_q.push_back(2'd1);
      serve(1, 0, ch, dk, rs, hd, hr, to);
      e = exp_q.pop_front();
      n_total++; if (ch !== e || to) $display("FAIL abort_setup_channel: got %0d want %0d", ch, e); else n_pass++;
      idle_out();

      bus.dreq = 4'b1111;
      exp_q.push_back(2'd2);
      for (int i = 0; i < 20 && bus.hrq !== 1'b1; i++) @(negedge clk);
      bus.hlda = 1'b1;
      for (int i = 0; i < 10 && bus.grantValid !== 1'b1; i++) @(negedge clk);
      e = exp_q.pop_front();
      n_total++; if (bus.grantValid !== 1'b1 || bus.grantChannel !== e) $display("FAIL abort_grant: got valid %b ch %0d want 1 ch %0d", bus.grantValid, bus.grantChannel, e); else n_pass++;
      bus.hlda = 1'b0;
      @(negedge clk);
      n_total++; if (bus.grantValid !== 1'b0) $display("FAIL abort_grantValid: got %b want 0", bus.grantValid); else n_pass++;
      n_total++; if (bus.reqServed !== 4'b0000) $display("FAIL abort_reqServed: got %b want 0000", bus.reqServed); else n_pass++;
      n_total++; if (bus.hrq !== 1'b0) $display("FAIL abort_hrq: got %b want 0", bus.hrq); else n_pass++;
      exp_q.push_back(2'd2);
      serve(1, 0, ch, dk, rs, hd, hr, to);
      e = exp_q.pop_front();
      n_total++; if (ch !== e || to) $display("FAIL abort_lowpri_kept: got %0d want %0d", ch, e); else n_pass++;
      idle_out();

      controllerDisable = 1'b1;
      bus.dreq = 4'b0001;
      step(LAT + 3);
      n_total++; if (bus.hrq !== 1'b0) $display("FAIL disable_hrq: got %b want 0", bus.hrq); else n_pass++;
      idle_out();
      controllerDisable = 1'b0;
   endtask

   task automatic test_reset_mid_grant();
      logic [1:0] ch; logic [3:0] dk, rs; logic hd, hr; bit to; logic [1:0] e;
      priorityType = 1'b1;
      bus.dreq = 4'b0001;
      exp_q.push_back(2'd0);
      serve(1, 0, ch, dk, rs, hd, hr, to);
      e = exp_q.pop_front();
      n_total++; if (ch !== e || to) $display("FAIL midrst_setup_channel: got %0d want %0d", ch, e); else n_pass++;
      for (int i = 0; i < 20 && bus.hrq !== 1'b1; i++) @(negedge clk);
      bus.hlda = 1'b1;
      for (int i = 0; i < 10 && bus.grantValid !== 1'b1; i++) @(negedge clk);
      bus.serviceDone = 1'b1;
      resetN = 1'b0;
      #1;
      n_total++; if (bus.hrq !== 1'b0) $display("FAIL midrst_hrq: got %b want 0", bus.hrq); else n_pass++;
      n_total++; if (bus.grantValid !== 1'b0) $display("FAIL midrst_grantValid: got %b want 0", bus.grantValid); else n_pass++;
      n_total++; if (bus.reqServed !== 4'b0000) $display("FAIL midrst_reqServed: got %b want 0000", bus.reqServed); else n_pass++;
      @(negedge clk);
      bus.serviceDone = 1'b0;
      bus.hlda = 1'b0;
      bus.dreq = 4'b0011;
      resetN = 1'b1;
      exp_q.push_back(2'd0);
      serve(1, 0, ch, dk, rs, hd, hr, to);
      e = exp_q.pop_front();
      n_total++; if (ch !== e || to) $display("FAIL midrst_lowpri_reset: got %0d want %0d", ch, e); else n_pass++;
      idle_out();
   endtask

   task automatic test_latency();
      int lat;
      lat = 0;
      bus.dreq = 4'b0001;
      for (int i = 1; i <= 10; i++) begin
         @(posedge clk);
         #1;
         if (bus.hrq === 1'b1) begin
            lat = i;
            break;
         end
      end
      n_total++; if (lat != LAT) $display("FAIL dreq_hrq_latency: got %0d want %0d", lat, LAT); else n_pass++;
      @(negedge clk);
      idle_out();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      n_pass            = 0;
      n_total           = 0;
      resetN            = 1'b0;
      maskBits          = 4'b0000;
      softReq           = 4'b0000;
      priorityType      = 1'b0;
      dreqSense         = 1'b0;
      dackSense         = 1'b0;
      controllerDisable = 1'b0;
      bus.dreq          = 4'b0000;
      bus.hlda          = 1'b0;
      bus.serviceDone   = 1'b0;
      @(negedge clk);
      test_reset();
      test_fixed();
      test_rotating();
      test_mask_softreq();
      test_sense();
      test_withdraw_abort_disable();
      test_reset_mid_grant();
      test_latency();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
